// File: rtl/sprite_mover.sv
// Per-sprite position block: frame-divided moves, buffered turns at tile alignment,
// wall checks over a req/ack port. Define SPRITE_MOVER_TUNNEL_EN to wrap x through the side tunnel.
module sprite_mover #(
  parameter int         COORD_W    = 10,
  parameter int         TILE_SHIFT = 4,
  parameter int         STEP       = 1,
  parameter int         FRAME_DIV  = 1,
  parameter int         START_X    = 304,
  parameter int         START_Y    = 288,
  parameter logic [1:0] START_DIR  = 2'b11,
  parameter int         SCREEN_W   = 640
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Restart,
  input  logic                        frame_clk,
  input  logic [2:0]                  direction,
  output logic                        wall_req,
  output logic [COORD_W-TILE_SHIFT-1:0] wall_tx,
  output logic [COORD_W-TILE_SHIFT-1:0] wall_ty,
  input  logic                        wall_ack,
  input  logic                        wall_blocked,
  output logic [COORD_W-1:0]          pos_x,
  output logic [COORD_W-1:0]          pos_y,
  output logic [1:0]                  cur_dir,
  output logic                        moving,
  output logic                        step_pulse
);
  localparam int TW    = COORD_W - TILE_SHIFT;
  localparam int XW    = COORD_W + 1;
  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [XW-1:0]    STEP_X   = XW'(STEP);
  localparam logic [XW-1:0]    X_MAX    = XW'(SCREEN_W - (1 << TILE_SHIFT));
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  localparam logic [1:0] D_UP = 2'b00, D_RIGHT = 2'b01, D_DOWN = 2'b10, D_LEFT = 2'b11;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_TURN_Q = 2'd1;
  localparam logic [1:0] S_FWD_Q  = 2'd2;
  localparam logic [1:0] S_MOVE   = 2'd3;

  logic             f0, f1, tick, go;
  logic [DIV_W-1:0] div;
  logic [1:0]       state, q_dir, pend_dir;
  logic             pend_v, aligned, reverse;
  logic [TW-1:0]    tx, ty;
  logic [COORD_W-1:0] nx, ny;
  logic             step_ok;

  assign tick     = f0 & ~f1;
  assign go       = tick && (div == DIV_LAST);
  assign aligned  = (pos_x[TILE_SHIFT-1:0] == '0) && (pos_y[TILE_SHIFT-1:0] == '0);
  assign reverse  = pend_v && (pend_dir == (cur_dir ^ 2'b10));
  assign tx       = pos_x[COORD_W-1:TILE_SHIFT];
  assign ty       = pos_y[COORD_W-1:TILE_SHIFT];
  assign wall_req = (state == S_TURN_Q) || (state == S_FWD_Q);

  // q_dir is latched on query entry so the tile stays put even if a new request lands mid-query.
  always_comb begin
    wall_tx = tx;
    wall_ty = ty;
    case (q_dir)
      D_UP:    wall_ty = ty - TW'(1);
      D_RIGHT: wall_tx = tx + TW'(1);
      D_DOWN:  wall_ty = ty + TW'(1);
      default: wall_tx = tx - TW'(1);
    endcase
  end

  always_comb begin
    nx      = pos_x;
    ny      = pos_y;
    step_ok = 1'b1;
    case (cur_dir)
      D_UP:   ny = pos_y - COORD_W'(STEP);
      D_DOWN: ny = pos_y + COORD_W'(STEP);
      D_RIGHT: begin
        if (({1'b0, pos_x} + STEP_X) > X_MAX) begin
`ifdef SPRITE_MOVER_TUNNEL_EN
          nx = '0;
`else
          step_ok = 1'b0;
`endif
        end else begin
          nx = pos_x + COORD_W'(STEP);
        end
      end
      default: begin
        if ({1'b0, pos_x} < STEP_X) begin
`ifdef SPRITE_MOVER_TUNNEL_EN
          nx = X_MAX[COORD_W-1:0];
`else
          step_ok = 1'b0;
`endif
        end else begin
          nx = pos_x - COORD_W'(STEP);
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset || Restart) begin
      pos_x      <= COORD_W'(START_X);
      pos_y      <= COORD_W'(START_Y);
      cur_dir    <= START_DIR;
      q_dir      <= START_DIR;
      pend_dir   <= START_DIR;
      pend_v     <= 1'b0;
      div        <= '0;
      f0         <= 1'b0;
      f1         <= 1'b0;
      state      <= S_IDLE;
      moving     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      f0         <= frame_clk;
      f1         <= f0;
      step_pulse <= 1'b0;
      if (tick) div <= go ? '0 : div + DIV_W'(1);

      case (state)
        S_IDLE: if (go) begin
          if (reverse) begin
            cur_dir <= pend_dir;
            pend_v  <= 1'b0;
            state   <= S_MOVE;
          end else if (aligned && pend_v && (pend_dir != cur_dir)) begin
            q_dir <= pend_dir;
            state <= S_TURN_Q;
          end else if (aligned) begin
            q_dir <= cur_dir;
            state <= S_FWD_Q;
          end else begin
            state <= S_MOVE;
          end
        end
        S_TURN_Q: if (wall_ack) begin
          if (!wall_blocked) begin
            cur_dir <= q_dir;
            pend_v  <= 1'b0;
            state   <= S_MOVE;
          end else begin
            q_dir <= cur_dir;
            state <= S_FWD_Q;
          end
        end
        S_FWD_Q: if (wall_ack) begin
          if (!wall_blocked) begin
            state <= S_MOVE;
          end else begin
            moving <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          if (step_ok) begin
            pos_x <= nx;
            pos_y <= ny;
          end
          moving     <= step_ok;
          step_pulse <= step_ok;
          state      <= S_IDLE;
        end
      endcase

      // A fresh request overrides any same-cycle clear: the latest request wins.
      if (direction[2]) begin
        pend_v   <= 1'b1;
        pend_dir <= direction[1:0];
      end
    end
  end
endmodule
